id_stage_pipe: RTL and testbench

//  MIPS decode stage plus ID/EX pipeline register. Decodes a 32-bit instruction into control signals.

---
 rtl/id_stage_pipe_pkg.sv | 71 +++++++
 rtl/id_stage_pipe_reg_file.sv | 46 ++++
 rtl/id_stage_pipe.sv | 89 ++++++++
 tb/tb_id_stage_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and the ID/EX bundle
// for the MIPS instruction-decode stage.
package id_stage_pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        ctrl_t             ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    // Unrecognised opcodes fall through to an all-zero bubble.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            (op == OP_LW): begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            (op == OP_SW): begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            (op == OP_BEQ): begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipe_reg_file.sv
// 2-read / 1-write register file with $0 hardwired
// to zero and same-cycle write-to-read bypass.
module reg_file
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int size   = 32,
    parameter int AW     = $clog2(size)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    logic [DATA_W-1:0] Data_register [0:size-1];
    logic              wr_en;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < size; i++) begin
                Data_register[i] <= '0;
            end
        end else if (wr_en) begin
            Data_register[wa_i] <= wd_i;
        end
    end

    // WB writes in the first half of the cycle from ID's point of view.
    always_comb begin
        rd1_o = Data_register[ra1_i];
        rd2_o = Data_register[ra2_i];
        if (wr_en && wa_i == ra1_i) rd1_o = wd_i;
        if (wr_en && wa_i == ra2_i) rd2_o = wd_i;
        if (ra1_i == '0) rd1_o = '0;
        if (ra2_i == '0) rd2_o = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: control decode, operand read,
// sign extension and the ID/EX pipeline register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = id_stage_pipe_pkg::DATA_W,
    parameter int NUM_REGS = id_stage_pipe_pkg::NUM_REGS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] PC_plus_four_in,
    input  logic [31:0]       instruction,
    input  logic              RegWrite_in,
    input  logic [4:0]        WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] PC_plus_four_out,
    output logic              ALUSrc,
    output logic              RegDst,
    output logic              MemWrite,
    output logic              MemRead,
    output logic              Branch,
    output logic              MemToReg,
    output logic              RegWrite_out,
    output logic [1:0]        ALUOp,
    output logic [DATA_W-1:0] ReadData_1,
    output logic [DATA_W-1:0] ReadData_2,
    output logic [DATA_W-1:0] Immediate,
    output logic [4:0]        RegisterRs,
    output logic [4:0]        RegisterRt,
    output logic [4:0]        RegisterRd
);

    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    reg_file #(
        .DATA_W (DATA_W),
        .size   (NUM_REGS)
    ) u_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .ra1_i   (instruction[25:21]),
        .ra2_i   (instruction[20:16]),
        .we_i    (RegWrite_in),
        .wa_i    (WriteRegister),
        .wd_i    (WriteData),
        .rd1_o   (rd1),
        .rd2_o   (rd2)
    );

    always_comb begin
        id_ex_d      = '0;
        id_ex_d.pc4  = PC_plus_four_in;
        id_ex_d.ctrl = decode(instruction[31:26]);
        id_ex_d.rd1  = rd1;
        id_ex_d.rd2  = rd2;
        id_ex_d.imm  = {{16{instruction[15]}}, instruction[15:0]};
        id_ex_d.rs   = instruction[25:21];
        id_ex_d.rt   = instruction[20:16];
        id_ex_d.rd   = instruction[15:11];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign PC_plus_four_out = id_ex_q.pc4;
    assign ALUSrc           = id_ex_q.ctrl.alu_src;
    assign RegDst           = id_ex_q.ctrl.reg_dst;
    assign MemWrite         = id_ex_q.ctrl.mem_write;
    assign MemRead          = id_ex_q.ctrl.mem_read;
    assign Branch           = id_ex_q.ctrl.branch;
    assign MemToReg         = id_ex_q.ctrl.mem_to_reg;
    assign RegWrite_out     = id_ex_q.ctrl.reg_write;
    assign ALUOp            = id_ex_q.ctrl.alu_op;
    assign ReadData_1       = id_ex_q.rd1;
    assign ReadData_2       = id_ex_q.rd2;
    assign Immediate        = id_ex_q.imm;
    assign RegisterRs       = id_ex_q.rs;
    assign RegisterRt       = id_ex_q.rt;
    assign RegisterRd       = id_ex_q.rd;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: behavioural model
// compared every cycle plus hand-computed spot checks.
module tb_id_stage_pipe;

    logic        clock;
    logic        reset_n;
    logic [31:0] PC_plus_four_in;
    logic [31:0] instruction;
    logic        RegWrite_in;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] PC_plus_four_out;
    logic        ALUSrc, RegDst, MemWrite, MemRead;
    logic        Branch, MemToReg, RegWrite_out;
    logic [1:0]  ALUOp;
    logic [31:0] ReadData_1, ReadData_2, Immediate;
    logic [4:0]  RegisterRs, RegisterRt, RegisterRd;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    id_stage_pipe dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .PC_plus_four_in  (PC_plus_four_in),
        .instruction      (instruction),
        .RegWrite_in      (RegWrite_in),
        .WriteRegister    (WriteRegister),
        .WriteData        (WriteData),
        .PC_plus_four_out (PC_plus_four_out),
        .ALUSrc           (ALUSrc),
        .RegDst           (RegDst),
        .MemWrite         (MemWrite),
        .MemRead          (MemRead),
        .Branch           (Branch),
        .MemToReg         (MemToReg),
        .RegWrite_out     (RegWrite_out),
        .ALUOp            (ALUOp),
        .ReadData_1       (ReadData_1),
        .ReadData_2       (ReadData_2),
        .Immediate        (Immediate),
        .RegisterRs       (RegisterRs),
        .RegisterRt       (RegisterRt),
        .RegisterRd       (RegisterRd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Control table, columns:
    // {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
    function automatic logic [8:0] ctrl_table(input logic [5:0] op);
        case (op)
            6'd0:    return 9'b1_0_0_1_0_0_0_10;
            6'd35:   return 9'b0_1_1_1_1_0_0_00;
            6'd43:   return 9'b0_1_0_0_0_1_0_00;
            6'd4:    return 9'b0_0_0_0_0_0_1_01;
            default: return 9'b0;
        endcase
    endfunction

    logic [31:0] mrf [32];
    logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
    logic [8:0]  e_ctl;
    logic [4:0]  e_rs, e_rt, e_rd;

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite_in && WriteRegister == a) return WriteData;
        return mrf[a];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mrf[i] <= 32'd0;
            e_pc <= 0; e_rd1 <= 0; e_rd2 <= 0; e_imm <= 0;
            e_ctl <= 0; e_rs <= 0; e_rt <= 0; e_rd <= 0;
        end else begin
            e_pc  <= PC_plus_four_in;
            e_ctl <= ctrl_table(instruction[31:26]);
            e_rs  <= instruction[25:21];
            e_rt  <= instruction[20:16];
            e_rd  <= instruction[15:11];
            e_rd1 <= mread(instruction[25:21]);
            e_rd2 <= mread(instruction[20:16]);
            e_imm <= 32'($signed(instruction[15:0]));
            if (RegWrite_in && WriteRegister != 5'd0)
                mrf[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [8:0] dut_ctl();
        return {RegDst, ALUSrc, MemToReg, RegWrite_out,
                MemRead, MemWrite, Branch, ALUOp};
    endfunction

    always @(negedge clock) begin
        if (started) begin
            chk("pc4", PC_plus_four_out, e_pc);
            chk("ctrl", 32'(dut_ctl()), 32'(e_ctl));
            chk("rd1", ReadData_1, e_rd1);
            chk("rd2", ReadData_2, e_rd2);
            chk("imm", Immediate, e_imm);
            chk("rs", 32'(RegisterRs), 32'(e_rs));
            chk("rt", 32'(RegisterRt), 32'(e_rt));
            chk("rd", 32'(RegisterRd), 32'(e_rd));
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] acc;
        acc = PC_plus_four_out | ReadData_1 | ReadData_2 | Immediate
            | 32'(dut_ctl()) | 32'(RegisterRs) | 32'(RegisterRt)
            | 32'(RegisterRd);
        chk({tag, "_outs"}, acc, 32'd0);
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc |= dut.u_rf.Data_register[i];
        chk({tag, "_regs"}, acc, 32'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        PC_plus_four_in = 0; instruction = 0;
        RegWrite_in = 0; WriteRegister = 0; WriteData = 0;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        started = 1;
        repeat (2) step();
        reset_n = 1'b1;

        RegWrite_in = 1; WriteRegister = 8; WriteData = 32'h000CCCCC;
        step();
        WriteRegister = 9; WriteData = 32'h000DDDDD;
        step();
        RegWrite_in = 0;
        instruction = 32'h01098820; PC_plus_four_in = 32'h0000FFFF;
        step();
        chk("add_rd1", ReadData_1, 32'h000CCCCC);
        chk("add_rd2", ReadData_2, 32'h000DDDDD);
        chk("add_regs", {RegisterRs, RegisterRt, RegisterRd},
            {5'd8, 5'd9, 5'd17});
        chk("add_ctl", 32'(dut_ctl()), 32'b1_0_0_1_0_0_0_10);
        chk("add_imm", Immediate, 32'hFFFF8820);
        chk("add_pc", PC_plus_four_out, 32'h0000FFFF);

        RegWrite_in = 1; WriteRegister = 9; WriteData = 32'h0BADBAD0;
        instruction = 32'h0;
        step();
        instruction = 32'h01098820; WriteData = 32'h000DDDDD;
        step();
        chk("bypass_rd2", ReadData_2, 32'h000DDDDD);
        RegWrite_in = 0;

        instruction = 32'h8D0A0004;
        step();
        chk("lw_ctl", 32'(dut_ctl()), 32'b0_1_1_1_1_0_0_00);
        chk("lw_imm", Immediate, 32'h00000004);
        chk("lw_rt", 32'(RegisterRt), 32'd10);

        instruction = 32'hAD0A0008;
        step();
        chk("sw_mw_rw", {MemWrite, RegWrite_out}, 2'b10);
        instruction = 32'h1109FFFF;
        step();
        chk("beq_br_op", {Branch, ALUOp}, 3'b101);
        chk("beq_imm", Immediate, 32'hFFFFFFFF);

        RegWrite_in = 1; WriteRegister = 0; WriteData = 32'h12345678;
        instruction = 32'h00000020;
        step();
        chk("r0_bypass", ReadData_1 | ReadData_2, 32'd0);
        RegWrite_in = 0;
        step();
        chk("r0_read", ReadData_1, 32'd0);
        chk("r0_array", dut.u_rf.Data_register[0], 32'd0);

        WriteRegister = 8; WriteData = 32'hFFFFFFFF;
        instruction = 32'h01098820;
        step();
        chk("nowe_same", ReadData_1, 32'h000CCCCC);
        step();
        chk("nowe_after", ReadData_1, 32'h000CCCCC);

        instruction = 32'hFD0A1234;
        step();
        chk("unk_ctl", 32'(dut_ctl()), 32'd0);
        chk("unk_imm", Immediate, 32'h00001234);

        instruction = 32'h8D0A0004;
        step();
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clock);
        #1 reset_n = 1'b1;
        instruction = 32'h01098820; PC_plus_four_in = 32'h00000100;
        step();
        chk("post_rw", 32'(RegWrite_out), 32'd1);
        chk("post_rd", 32'(RegisterRd), 32'd17);
        chk("post_rd1", ReadData_1, 32'd0);
        chk("post_pc", PC_plus_four_out, 32'h00000100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
